amci_cmd_sequencer: RTL and testbench
=====================================

Name: amci_cmd_sequencer

Overview:
- Upstream driver for the AMCI user port of the single-beat AXI4 master.
- Accepts a valid/ready command stream of write, read and poll operations, issues them one at a time as AMCI pulses, and waits for the master's idle flags.
- Returns read and poll results on a valid/ready response stream.
- Lets firmware-style sequences run from a FIFO without custom FSMs.

Parameters:
- AXI_DATA_WIDTH, 32, data width; must match the AXI master.
- AXI_ADDR_WIDTH, 32, address width; must match the AXI master.
- POLL_MAX_TRIES, 1024, reads a poll performs before reporting timeout (>=1).

Ports:
- clk  in  1  clock, shared with the AXI master clock.
- reset  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  command accepted when VALID&READY.
- CMD_OP  in  2  0=write, 1=read, 2=poll, 3=NOP.
- CMD_ADDR  in  AXI_ADDR_WIDTH  target address.
- CMD_DATA  in  AXI_DATA_WIDTH  write data (write) or compare value (poll).
- CMD_MASK  in  AXI_DATA_WIDTH  poll compare mask; ignored otherwise.
- CMD_STRB  in  AXI_DATA_WIDTH/8  write strobes; 0 means all lanes (master rule).
- RSP_VALID  out  1  response present.
- RSP_READY  in  1  response consumed.
- RSP_DATA  out  AXI_DATA_WIDTH  last data read.
- RSP_ADDR  out  AXI_ADDR_WIDTH  address of the command.
- RSP_TIMEOUT  out  1  1 = poll exhausted POLL_MAX_TRIES.
- AMCI_WADDR, AMCI_WDATA, AMCI_WSTRB  out  widths as above  to master.
- AMCI_WRITE  out  1  one-cycle write start pulse.
- AMCI_WIDLE  in  1  master write FSM idle.
- AMCI_RADDR  out  AXI_ADDR_WIDTH  to master.
- AMCI_READ  out  1  one-cycle read start pulse.
- AMCI_RDATA  in  AXI_DATA_WIDTH  read result.
- AMCI_RIDLE  in  1  master read FSM idle.
- WR_COUNT  out  32  completed writes; wraps at 2^32.
- RD_COUNT  out  32  completed AMCI reads, including each poll attempt; wraps.
- BUSY  out  1  state != IDLE.

Behaviour:
- Reset (sync, active-high): state IDLE; CMD_READY, RSP_VALID, RSP_TIMEOUT, AMCI_WRITE, AMCI_READ, BUSY = 0; all data/address outputs = 0; counters = 0; poll try counter = 0. Reset mid-operation abandons the transaction; the AXI master must be reset in the same cycle.
- CMD_READY = (state==IDLE) & AMCI_WIDLE & AMCI_RIDLE. This is combinational from registered state and the inputs; it never depends on CMD_VALID.
- The command is registered on accept. Only one transaction is in flight; no pipelining.
- States: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, RSP_HOLD.
- IDLE, on accept:
  - OP=0 -> WR_ISSUE, with AMCI_WADDR/WDATA/WSTRB loaded.
  - OP=1 or 2 -> RD_ISSUE, with AMCI_RADDR loaded and try counter = 0.
  - OP=3 -> stay IDLE (consumed, no bus activity, no response).
- WR_ISSUE: AMCI_WRITE=1 for exactly this cycle -> WR_WAIT.
- WR_WAIT: AMCI_WIDLE is not sampled in the first cycle after the pulse. From the next cycle on, AMCI_WIDLE=1 -> WR_COUNT+1, IDLE. Writes produce no response. Minimum write occupancy: accept + 3 cycles plus slave latency.
- RD_ISSUE: AMCI_READ=1 for exactly this cycle -> RD_WAIT.
- RD_WAIT: same one-cycle skip. When AMCI_RIDLE=1: capture AMCI_RDATA into RSP_DATA and increment RD_COUNT.
  - Read: -> RSP_HOLD, RSP_TIMEOUT=0.
  - Poll match, ((RDATA^CMD_DATA)&CMD_MASK)==0: -> RSP_HOLD, RSP_TIMEOUT=0.
  - Poll mismatch with try+1 == POLL_MAX_TRIES: -> RSP_HOLD, RSP_TIMEOUT=1.
  - Otherwise: try+1 and -> RD_ISSUE (back-to-back reissue).
- RSP_HOLD: RSP_VALID=1, with RSP_DATA/ADDR/TIMEOUT held stable until RSP_READY. On VALID&READY -> RSP_VALID=0, IDLE. The next command is accepted no earlier than the following cycle.
- A poll with mask 0 always matches on the first read.
- AMCI_WRITE and AMCI_READ are never high together; each is high at most one cycle per transaction.

Test Plan:
- Write 0x1000 <- 0xDEADBEEF, STRB=0xF; slave BVALID 2 cycles after W handshake -> single AMCI_WRITE pulse with those values; WR_COUNT=1; CMD_READY low until WIDLE returns; no RSP_VALID.
- Read 0x2000, slave returns 0x12345678; RSP_READY held low 5 cycles -> RSP_VALID stays 1 with stable RSP_DATA=0x12345678, RSP_ADDR=0x2000, TIMEOUT=0; drops the cycle after READY.
- Poll 0x3000, mask 0x1, compare 0x1; slave returns 0,0,1 -> three AMCI_READ pulses, RD_COUNT=3, RSP_DATA=0x1, TIMEOUT=0.
- Poll with POLL_MAX_TRIES=4, slave always returns 0 -> exactly 4 reads, RSP_TIMEOUT=1, RSP_DATA=0.
- Back-to-back stream of NOP, write, read with CMD_VALID held high -> NOP consumed in 1 cycle with no AMCI activity; write then read executed strictly in order; one response.
- Reset asserted during RD_WAIT (master reset too) -> next cycle all outputs 0, counters 0, CMD_READY=1 once idles are high; a fresh read completes normally.

Source files
------------

// File: rtl/amci_cmd_sequencer_if.sv
// Command, response and AMCI user-port signals of the command sequencer.
// Modport "master" is the sequencer's view; "slave" is the command source, response sink and AXI master.
interface amci_cmd_sequencer_if #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32
);
    logic                          CMD_VALID;
    logic                          CMD_READY;
    logic [1:0]                    CMD_OP;
    logic [AXI_ADDR_WIDTH-1:0]     CMD_ADDR;
    logic [AXI_DATA_WIDTH-1:0]     CMD_DATA;
    logic [AXI_DATA_WIDTH-1:0]     CMD_MASK;
    logic [AXI_DATA_WIDTH/8-1:0]   CMD_STRB;

    logic                          RSP_VALID;
    logic                          RSP_READY;
    logic [AXI_DATA_WIDTH-1:0]     RSP_DATA;
    logic [AXI_ADDR_WIDTH-1:0]     RSP_ADDR;
    logic                          RSP_TIMEOUT;

    logic [AXI_ADDR_WIDTH-1:0]     AMCI_WADDR;
    logic [AXI_DATA_WIDTH-1:0]     AMCI_WDATA;
    logic [AXI_DATA_WIDTH/8-1:0]   AMCI_WSTRB;
    logic                          AMCI_WRITE;
    logic                          AMCI_WIDLE;
    logic [AXI_ADDR_WIDTH-1:0]     AMCI_RADDR;
    logic                          AMCI_READ;
    logic [AXI_DATA_WIDTH-1:0]     AMCI_RDATA;
    logic                          AMCI_RIDLE;

    // Handshakes: a command transfers on a rising clk edge where CMD_VALID & CMD_READY; a response
    // transfers where RSP_VALID & RSP_READY. Payloads stay stable while VALID is high and READY is low.
    modport master (
        input  CMD_VALID, CMD_OP, CMD_ADDR, CMD_DATA, CMD_MASK, CMD_STRB,
        output CMD_READY,
        output RSP_VALID, RSP_DATA, RSP_ADDR, RSP_TIMEOUT,
        input  RSP_READY,
        output AMCI_WADDR, AMCI_WDATA, AMCI_WSTRB, AMCI_WRITE, AMCI_RADDR, AMCI_READ,
        input  AMCI_WIDLE, AMCI_RDATA, AMCI_RIDLE
    );

    modport slave (
        output CMD_VALID, CMD_OP, CMD_ADDR, CMD_DATA, CMD_MASK, CMD_STRB,
        input  CMD_READY,
        input  RSP_VALID, RSP_DATA, RSP_ADDR, RSP_TIMEOUT,
        output RSP_READY,
        input  AMCI_WADDR, AMCI_WDATA, AMCI_WSTRB, AMCI_WRITE, AMCI_RADDR, AMCI_READ,
        output AMCI_WIDLE, AMCI_RDATA, AMCI_RIDLE
    );
endinterface

// File: rtl/amci_cmd_sequencer.sv
// Runs write/read/poll commands one at a time against the AMCI user port of the single-beat AXI master
// and returns read/poll results on a response stream.
module amci_cmd_sequencer #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int POLL_MAX_TRIES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    amci_cmd_sequencer_if.master bus,
    output logic [31:0]          WR_COUNT,
    output logic [31:0]          RD_COUNT,
    output logic                 BUSY,
    output logic [2:0]           state_o
);
    localparam int SW    = AXI_DATA_WIDTH / 8;
    localparam int TRY_W = (POLL_MAX_TRIES > 1) ? $clog2(POLL_MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(POLL_MAX_TRIES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_ISSUE = 3'd1,
        S_WR_WAIT  = 3'd2,
        S_RD_ISSUE = 3'd3,
        S_RD_WAIT  = 3'd4,
        S_RSP_HOLD = 3'd5
    } state_t;

    state_t                    state_q;
    logic                      skip_q;
    logic                      is_poll_q;
    logic [AXI_DATA_WIDTH-1:0] cmp_q;
    logic [AXI_DATA_WIDTH-1:0] mask_q;
    logic [TRY_W-1:0]          try_q;
    logic                      write_q;
    logic                      read_q;
    logic [AXI_ADDR_WIDTH-1:0] waddr_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic [SW-1:0]             wstrb_q;
    logic [AXI_ADDR_WIDTH-1:0] raddr_q;
    logic                      rsp_valid_q;
    logic [AXI_DATA_WIDTH-1:0] rsp_data_q;
    logic                      rsp_timeout_q;
    logic [31:0]               wr_count_q;
    logic [31:0]               rd_count_q;

    logic cmd_ready_d;
    logic poll_match_d;

    // Reset gating keeps CMD_READY low while the master is still being reset alongside us.
    assign cmd_ready_d  = !reset && (state_q == S_IDLE) && bus.AMCI_WIDLE && bus.AMCI_RIDLE;
    assign poll_match_d = ((bus.AMCI_RDATA ^ cmp_q) & mask_q) == '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            skip_q        <= 1'b0;
            is_poll_q     <= 1'b0;
            cmp_q         <= '0;
            mask_q        <= '0;
            try_q         <= '0;
            write_q       <= 1'b0;
            read_q        <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            raddr_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            wr_count_q    <= '0;
            rd_count_q    <= '0;
        end else begin
            write_q <= 1'b0;
            read_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.CMD_VALID && cmd_ready_d) begin
                        case (bus.CMD_OP)
                            2'd0: begin
                                waddr_q <= bus.CMD_ADDR;
                                wdata_q <= bus.CMD_DATA;
                                wstrb_q <= bus.CMD_STRB;
                                write_q <= 1'b1;
                                state_q <= S_WR_ISSUE;
                            end
                            2'd1, 2'd2: begin
                                raddr_q   <= bus.CMD_ADDR;
                                is_poll_q <= (bus.CMD_OP == 2'd2);
                                cmp_q     <= bus.CMD_DATA;
                                mask_q    <= bus.CMD_MASK;
                                try_q     <= '0;
                                read_q    <= 1'b1;
                                state_q   <= S_RD_ISSUE;
                            end
                            default: state_q <= S_IDLE;
                        endcase
                    end
                end
                S_WR_ISSUE: begin
                    skip_q  <= 1'b1;
                    state_q <= S_WR_WAIT;
                end
                // The master's idle flag still reads high in the cycle right after the pulse.
                S_WR_WAIT: begin
                    if (skip_q) begin
                        skip_q <= 1'b0;
                    end else if (bus.AMCI_WIDLE) begin
                        wr_count_q <= wr_count_q + 32'd1;
                        state_q    <= S_IDLE;
                    end
                end
                S_RD_ISSUE: begin
                    skip_q  <= 1'b1;
                    state_q <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (skip_q) begin
                        skip_q <= 1'b0;
                    end else if (bus.AMCI_RIDLE) begin
                        rsp_data_q <= bus.AMCI_RDATA;
                        rd_count_q <= rd_count_q + 32'd1;
                        if (!is_poll_q || poll_match_d) begin
                            rsp_valid_q   <= 1'b1;
                            rsp_timeout_q <= 1'b0;
                            state_q       <= S_RSP_HOLD;
                        end else if (try_q == TRY_LAST) begin
                            rsp_valid_q   <= 1'b1;
                            rsp_timeout_q <= 1'b1;
                            state_q       <= S_RSP_HOLD;
                        end else begin
                            try_q   <= try_q + 1'b1;
                            read_q  <= 1'b1;
                            state_q <= S_RD_ISSUE;
                        end
                    end
                end
                S_RSP_HOLD: begin
                    if (bus.RSP_READY) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.CMD_READY   = cmd_ready_d;
    assign bus.RSP_VALID   = rsp_valid_q;
    assign bus.RSP_DATA    = rsp_data_q;
    assign bus.RSP_ADDR    = raddr_q;
    assign bus.RSP_TIMEOUT = rsp_timeout_q;
    assign bus.AMCI_WADDR  = waddr_q;
    assign bus.AMCI_WDATA  = wdata_q;
    assign bus.AMCI_WSTRB  = wstrb_q;
    assign bus.AMCI_WRITE  = write_q;
    assign bus.AMCI_RADDR  = raddr_q;
    assign bus.AMCI_READ   = read_q;
    assign WR_COUNT        = wr_count_q;
    assign RD_COUNT        = rd_count_q;
    assign BUSY            = (state_q != S_IDLE);
    assign state_o         = state_q;
endmodule

// File: tb/tb_amci_cmd_sequencer.sv
// Directed bench for amci_cmd_sequencer: a behavioural AMCI master, a response scoreboard fed by the
// stimulus, and a pulse monitor on the AMCI start strobes.
module tb_amci_cmd_sequencer;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TRIES = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wr_count;
    logic [31:0] rd_count;
    logic        busy;
    logic [2:0]  state;

    always #5 clk = ~clk;

    amci_cmd_sequencer_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) bus();

    amci_cmd_sequencer #(
        .AXI_DATA_WIDTH(DW),
        .AXI_ADDR_WIDTH(AW),
        .POLL_MAX_TRIES(TRIES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.master),
        .WR_COUNT (wr_count),
        .RD_COUNT (rd_count),
        .BUSY     (busy),
        .state_o  (state)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Scoreboard: expected responses, pushed when a read/poll is issued.
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic          exp_to_q[$];
    int            n_rsp = 0;

    always @(negedge clk) begin
        if (!reset && bus.RSP_VALID && bus.RSP_READY) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                check("rsp_data", bus.RSP_DATA, exp_q.pop_front());
                check("rsp_addr", bus.RSP_ADDR, exp_addr_q.pop_front());
                check("rsp_timeout", {31'd0, bus.RSP_TIMEOUT}, {31'd0, exp_to_q.pop_front()});
            end
        end
    end

    // Pulse monitor
    int            wr_pulses = 0, rd_pulses = 0, ev_n = 0, last_wr_ev = 0, last_rd_ev = 0;
    int            both_high = 0, long_pulse = 0;
    logic          prev_wr = 1'b0, prev_rd = 1'b0;
    logic [AW-1:0] cap_waddr = '0;
    logic [DW-1:0] cap_wdata = '0;
    logic [3:0]    cap_wstrb = '0;

    always @(negedge clk) begin
        if (bus.AMCI_WRITE && bus.AMCI_READ) both_high++;
        if ((bus.AMCI_WRITE && prev_wr) || (bus.AMCI_READ && prev_rd)) long_pulse++;
        if (bus.AMCI_WRITE) begin
            wr_pulses++; ev_n++; last_wr_ev = ev_n;
            cap_waddr = bus.AMCI_WADDR; cap_wdata = bus.AMCI_WDATA; cap_wstrb = bus.AMCI_WSTRB;
        end
        if (bus.AMCI_READ) begin
            rd_pulses++; ev_n++; last_rd_ev = ev_n;
        end
        prev_wr = bus.AMCI_WRITE;
        prev_rd = bus.AMCI_READ;
    end

    // Behavioural AMCI master: idle flags drop after a start pulse for a configurable latency.
    int            w_lat = 3, r_lat = 1, wcnt = 0, rcnt = 0;
    logic [DW-1:0] slave_rd_q[$];
    logic [DW-1:0] pending = '0;

    initial begin
        bus.AMCI_WIDLE = 1'b1;
        bus.AMCI_RIDLE = 1'b1;
        bus.AMCI_RDATA = '0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                bus.AMCI_WIDLE = 1'b1; bus.AMCI_RIDLE = 1'b1; bus.AMCI_RDATA = '0;
                wcnt = 0; rcnt = 0; slave_rd_q.delete();
            end else begin
                if (!bus.AMCI_WIDLE) begin
                    wcnt--;
                    if (wcnt <= 0) bus.AMCI_WIDLE = 1'b1;
                end
                if (!bus.AMCI_RIDLE) begin
                    rcnt--;
                    if (rcnt <= 0) begin
                        bus.AMCI_RIDLE = 1'b1;
                        bus.AMCI_RDATA = pending;
                    end
                end
                if (bus.AMCI_WRITE) begin
                    bus.AMCI_WIDLE = 1'b0; wcnt = w_lat;
                end
                if (bus.AMCI_READ) begin
                    bus.AMCI_RIDLE = 1'b0; rcnt = r_lat;
                    pending = (slave_rd_q.size() != 0) ? slave_rd_q.pop_front() : 32'hBAD0_BAD0;
                end
            end
        end
    end

    // Driver tasks: called and returning at posedge+1.
    task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] mask, input logic [3:0] strb);
        int n;
        bus.CMD_OP = op; bus.CMD_ADDR = addr; bus.CMD_DATA = data;
        bus.CMD_MASK = mask; bus.CMD_STRB = strb; bus.CMD_VALID = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.CMD_READY && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("cmd_accept_timeout", n, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input logic [31:0] data, input logic [31:0] addr, input logic to);
        exp_q.push_back(data);
        exp_addr_q.push_back(addr);
        exp_to_q.push_back(to);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || !bus.CMD_READY) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("wait_idle_timeout", n, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, wr0, rd0, rsp0;
        reset = 1'b1;
        bus.CMD_VALID = 1'b0; bus.CMD_OP = 2'd3; bus.CMD_ADDR = '0; bus.CMD_DATA = '0;
        bus.CMD_MASK = '0; bus.CMD_STRB = '0; bus.RSP_READY = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", {31'd0, bus.CMD_READY}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.RSP_VALID}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wr_count", wr_count, 32'd0);
        check("rst_rd_count", rd_count, 32'd0);
        check("rst_waddr", bus.AMCI_WADDR, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", {31'd0, bus.CMD_READY}, 32'd1);
        @(posedge clk); #1;

        // Write 0x1000 <- 0xDEADBEEF
        send_cmd(2'd0, 32'h1000, 32'hDEAD_BEEF, 32'h0, 4'hF);
        bus.CMD_VALID = 1'b0;
        check("wr_busy_ready", {31'd0, bus.CMD_READY}, 32'd0);
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.CMD_READY) n++;
        end
        check("wr_ready_low", n, 0);
        wait_idle();
        check("wr_pulses", wr_pulses, 1);
        check("wr_rd_pulses", rd_pulses, 0);
        check("wr_waddr", cap_waddr, 32'h1000);
        check("wr_wdata", cap_wdata, 32'hDEAD_BEEF);
        check("wr_wstrb", {28'd0, cap_wstrb}, 32'hF);
        check("wr_count_1", wr_count, 32'd1);
        check("wr_no_rsp", n_rsp, 0);

        // Read 0x2000 with RSP_READY held low
        w_lat = 3; r_lat = 2;
        bus.RSP_READY = 1'b0;
        slave_rd_q.push_back(32'h1234_5678);
        expect_rsp(32'h1234_5678, 32'h2000, 1'b0);
        send_cmd(2'd1, 32'h2000, 32'h0, 32'h0, 4'h0);
        bus.CMD_VALID = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.RSP_VALID && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("rd_rsp_timeout", n, 0);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'd0, bus.RSP_VALID}, 32'd1);
            check("hold_data", bus.RSP_DATA, 32'h1234_5678);
            check("hold_addr", bus.RSP_ADDR, 32'h2000);
            check("hold_cmd_ready", {31'd0, bus.CMD_READY}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.RSP_READY = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rsp_drop", {31'd0, bus.RSP_VALID}, 32'd0);
        wait_idle();
        check("rd_count_1", rd_count, 32'd1);

        // Poll 0x3000 mask 1 compare 1: data 0,0,1
        r_lat = 1;
        rd0 = rd_pulses;
        slave_rd_q.push_back(32'h0); slave_rd_q.push_back(32'h0); slave_rd_q.push_back(32'h1);
        expect_rsp(32'h1, 32'h3000, 1'b0);
        send_cmd(2'd2, 32'h3000, 32'h1, 32'h1, 4'h0);
        bus.CMD_VALID = 1'b0;
        wait_idle();
        check("poll_reads", rd_pulses - rd0, 3);
        check("rd_count_4", rd_count, 32'd4);

        // Poll exhausts 4 tries
        rd0 = rd_pulses;
        repeat (4) slave_rd_q.push_back(32'h0);
        expect_rsp(32'h0, 32'h3004, 1'b1);
        send_cmd(2'd2, 32'h3004, 32'h1, 32'h1, 4'h0);
        bus.CMD_VALID = 1'b0;
        wait_idle();
        check("timeout_reads", rd_pulses - rd0, 4);
        check("rd_count_8", rd_count, 32'd8);

        // Poll with mask 0 matches on first read
        rd0 = rd_pulses;
        slave_rd_q.push_back(32'hA5A5);
        expect_rsp(32'hA5A5, 32'h3008, 1'b0);
        send_cmd(2'd2, 32'h3008, 32'hFFFF, 32'h0, 4'h0);
        bus.CMD_VALID = 1'b0;
        wait_idle();
        check("mask0_reads", rd_pulses - rd0, 1);

        // NOP, write, read with CMD_VALID held high
        wr0 = wr_pulses; rd0 = rd_pulses; rsp0 = n_rsp;
        slave_rd_q.push_back(32'h55);
        expect_rsp(32'h55, 32'h5000, 1'b0);
        send_cmd(2'd3, 32'h0, 32'h0, 32'h0, 4'h0);
        check("nop_idle", {31'd0, busy}, 32'd0);
        check("nop_no_pulse", (wr_pulses - wr0) + (rd_pulses - rd0), 0);
        send_cmd(2'd0, 32'h4000, 32'h11, 32'h0, 4'h0);
        send_cmd(2'd1, 32'h5000, 32'h0, 32'h0, 4'h0);
        bus.CMD_VALID = 1'b0;
        wait_idle();
        check("stream_wr", wr_pulses - wr0, 1);
        check("stream_rd", rd_pulses - rd0, 1);
        check("stream_order", {31'd0, last_wr_ev < last_rd_ev}, 32'd1);
        check("stream_wstrb", {28'd0, cap_wstrb}, 32'h0);
        check("stream_waddr", cap_waddr, 32'h4000);
        check("stream_rsps", n_rsp - rsp0, 1);
        check("wr_count_2", wr_count, 32'd2);
        check("rd_count_10", rd_count, 32'd10);

        // Reset during RD_WAIT
        r_lat = 10;
        slave_rd_q.push_back(32'h7777);
        send_cmd(2'd1, 32'h7000, 32'h0, 32'h0, 4'h0);
        bus.CMD_VALID = 1'b0;
        n = 0;
        @(negedge clk);
        while (state != 3'd4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reach_rd_wait", {29'd0, state}, 32'd4);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_rsp_valid", {31'd0, bus.RSP_VALID}, 32'd0);
        check("mid_rst_raddr", bus.AMCI_RADDR, 32'd0);
        check("mid_rst_waddr", bus.AMCI_WADDR, 32'd0);
        check("mid_rst_rsp_data", bus.RSP_DATA, 32'd0);
        check("mid_rst_wr_count", wr_count, 32'd0);
        check("mid_rst_rd_count", rd_count, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_cmd_ready", {31'd0, bus.CMD_READY}, 32'd1);
        @(posedge clk); #1;
        r_lat = 1;
        slave_rd_q.push_back(32'hCAFE_F00D);
        expect_rsp(32'hCAFE_F00D, 32'h6000, 1'b0);
        send_cmd(2'd1, 32'h6000, 32'h0, 32'h0, 4'h0);
        bus.CMD_VALID = 1'b0;
        wait_idle();
        check("fresh_rd_count", rd_count, 32'd1);
        check("fresh_wr_count", wr_count, 32'd0);

        repeat (3) @(posedge clk);
        check("never_both_pulses", both_high, 0);
        check("single_cycle_pulses", long_pulse, 0);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
